// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//
// Purpose:
//    Alarm-clock sequencing FSM. Once armed, a time match starts the buzzer.
//    The user can snooze, which silences the buzzer for SNOOZE_SEC ticks and
//    then rings again. The user can also turn the alarm off. If nobody reacts,
//    the alarm stops by itself after RING_TIMEOUT_SEC ticks. After the alarm
//    finishes, the block waits for the matching minute to pass before it
//    re-arms, so the same minute cannot trigger a second ring.
//
// Optional feature:
//    SNOOZE_LIMIT_EN  - When this macro is defined, the block counts how many
//                       times the user snoozes in one alarm episode. Snooze
//                       presses in RING are ignored once that count reaches
//                       MAX_SNOOZE. When the macro is undefined, snooze is
//                       unlimited and there is no tally logic.
//
// Ports:
//    clk         in   system clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    arm         in   alarm-enable switch (level)
//    match       in   current time equals the alarm time (level)
//    tick        in   one-cycle 1 Hz strobe
//    snooze_btn  in   snooze button level (debounced upstream)
//    off_btn     in   off button level (debounced upstream)
//    state       out  one-hot current state {DONE,SNOOZE,RING,ARMED,OFF}
//    buzzer      out  alarm sound enable (high in RING)
//    snooze_led  out  snooze indicator (high in SNOOZE)
// -----------------------------------------------------------------------------
module alarm_ctrl #(
   parameter int unsigned SNOOZE_SEC       = 9,
   parameter int unsigned RING_TIMEOUT_SEC = 60,
   parameter int unsigned MAX_SNOOZE       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arm,
   input  logic       match,
   input  logic       tick,
   input  logic       snooze_btn,
   input  logic       off_btn,
   output logic [4:0] state,
   output logic       buzzer,
   output logic       snooze_led
);

   typedef enum logic [4:0] {
      OFF    = 5'b00001,
      ARMED  = 5'b00010,
      RING   = 5'b00100,
      SNOOZE = 5'b01000,
      DONE   = 5'b10000
   } state_e;

   // Stop elaboration if a parameter is outside the range the 8-bit counters support.
   if (SNOOZE_SEC < 1 || SNOOZE_SEC > 255) begin : gBadSnoozeSec
      $error("alarm_ctrl: SNOOZE_SEC must be 1..255");
   end
   if (RING_TIMEOUT_SEC < 1 || RING_TIMEOUT_SEC > 255) begin : gBadRingTimeout
      $error("alarm_ctrl: RING_TIMEOUT_SEC must be 1..255");
   end
   if (MAX_SNOOZE > 255) begin : gBadMaxSnooze
      $error("alarm_ctrl: MAX_SNOOZE must be 0..255");
   end

   localparam logic [7:0] RingLast   = 8'(RING_TIMEOUT_SEC - 1);
   localparam logic [7:0] SnoozeLoad = 8'(SNOOZE_SEC);

   state_e     state_q, state_d;
   logic [7:0] ringCnt_q, ringCnt_d;
   logic [7:0] snoozeCnt_q, snoozeCnt_d;
   logic       snoozePrev_q, offPrev_q;
   logic       snoozePress, offPress;
   logic       snoozeAllowed;

   // A press is a rising edge on the button. Holding the button counts once.
   assign snoozePress = snooze_btn & ~snoozePrev_q;
   assign offPress    = off_btn & ~offPrev_q;

`ifdef SNOOZE_LIMIT_EN
   logic [7:0] snoozeTally_q, snoozeTally_d;

   assign snoozeAllowed = (snoozeTally_q < 8'(MAX_SNOOZE));

   // The tally counts RING->SNOOZE hops within one alarm episode. It is
   // forgotten whenever the episode ends, that is, on entry to OFF or DONE.
   always_comb begin
      snoozeTally_d = snoozeTally_q;
      if (state_d == OFF || state_d == DONE) begin
         snoozeTally_d = '0;
      end else if (state_q == RING && state_d == SNOOZE) begin
         snoozeTally_d = snoozeTally_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snoozeTally_q <= '0;
      end else begin
         snoozeTally_q <= snoozeTally_d;
      end
   end
`else
   assign snoozeAllowed = 1'b1;
`endif

   // Next-state logic. In every state except OFF, the conditions are checked in this
   // order: dropping arm, then an off press, then a snooze press, then timer or
   // match events. Because off is checked before snooze, pressing both together
   // ends in DONE. Any state value that is not one-hot falls back to OFF.
   always_comb begin
      state_d = state_q;
      case (state_q)
         OFF: begin
            if (arm) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (!arm) begin
               state_d = OFF;
            end else if (match) begin
               state_d = RING;
            end
         end
         RING: begin
            if (!arm) begin
               state_d = OFF;
            end else if (offPress) begin
               state_d = DONE;
            end else if (snoozePress && snoozeAllowed) begin
               state_d = SNOOZE;
            end else if (tick && ringCnt_q == RingLast) begin
               state_d = DONE;
            end
         end
         SNOOZE: begin
            if (!arm) begin
               state_d = OFF;
            end else if (offPress) begin
               state_d = DONE;
            end else if (tick && snoozeCnt_q == 8'd1) begin
               state_d = RING;
            end
         end
         DONE: begin
            if (!arm) begin
               state_d = OFF;
            end else if (!match) begin
               state_d = ARMED;
            end
         end
         default: begin
            state_d = OFF;
         end
      endcase
   end

   // The ring counter restarts at zero on every entry to RING, including the
   // return from SNOOZE. This gives each ring phase a full timeout window.
   // The snooze counter loads on entry to SNOOZE and counts down. It holds at
   // zero instead of wrapping.
   always_comb begin
      ringCnt_d   = ringCnt_q;
      snoozeCnt_d = snoozeCnt_q;

      if (state_d == RING && state_q != RING) begin
         ringCnt_d = '0;
      end else if (state_q == RING && tick) begin
         ringCnt_d = ringCnt_q + 8'd1;
      end

      if (state_d == SNOOZE && state_q != SNOOZE) begin
         snoozeCnt_d = SnoozeLoad;
      end else if (state_q == SNOOZE && tick && snoozeCnt_q != 8'd0) begin
         snoozeCnt_d = snoozeCnt_q - 8'd1;
      end
   end

   // State register, counters and button history. Reset puts the block in OFF
   // and drops any ring or snooze that was in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= OFF;
         ringCnt_q    <= '0;
         snoozeCnt_q  <= '0;
         snoozePrev_q <= 1'b0;
         offPrev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ringCnt_q    <= ringCnt_d;
         snoozeCnt_q  <= snoozeCnt_d;
         snoozePrev_q <= snooze_btn;
         offPrev_q    <= off_btn;
      end
   end

   // The outputs come straight from the state flops, so they add no delay.
   assign state      = state_q;
   assign buzzer     = state_q[2];
   assign snooze_led = state_q[3];

endmodule

// File: tb/tb_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ctrl
//
// Purpose:
//    Self-checking bench for alarm_ctrl with SNOOZE_SEC=3,
//    RING_TIMEOUT_SEC=4 and MAX_SNOOZE=2. Each stimulus cycle pushes the
//    expected {snooze_led, buzzer, state} into a queue. After the clock edge,
//    that entry is popped and compared with the DUT outputs.
//    The expected values for the third snooze press depend on SNOOZE_LIMIT_EN.
// -----------------------------------------------------------------------------
module tb_alarm_ctrl;

   localparam logic [4:0] S_OFF    = 5'b00001;
   localparam logic [4:0] S_ARMED  = 5'b00010;
   localparam logic [4:0] S_RING   = 5'b00100;
   localparam logic [4:0] S_SNOOZE = 5'b01000;
   localparam logic [4:0] S_DONE   = 5'b10000;

`ifdef SNOOZE_LIMIT_EN
   localparam logic [4:0] S_THIRD_SNOOZE = S_RING;
`else
   localparam logic [4:0] S_THIRD_SNOOZE = S_SNOOZE;
`endif

   logic       clk;
   logic       rst_n;
   logic       arm;
   logic       match;
   logic       tick;
   logic       snooze_btn;
   logic       off_btn;
   logic [4:0] state;
   logic       buzzer;
   logic       snooze_led;

   int         errors;
   int         checks;

   logic [6:0] expQ[$];
   string      tagQ[$];

   alarm_ctrl #(
      .SNOOZE_SEC      (3),
      .RING_TIMEOUT_SEC(4),
      .MAX_SNOOZE      (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arm       (arm),
      .match     (match),
      .tick      (tick),
      .snooze_btn(snooze_btn),
      .off_btn   (off_btn),
      .state     (state),
      .buzzer    (buzzer),
      .snooze_led(snooze_led)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench goes through this task. It counts the check
   // and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [6:0] actual, input logic [6:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got {led,buz,state}=%b expected %b", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and record the expected state
   // after the next rising edge. One #1 after that edge, pop and compare.
   task automatic applyStimulus(input logic a, input logic m, input logic t,
                                input logic s, input logic o,
                                input logic [4:0] expState, input string tag);
      logic [6:0] expVal;
      string      expTag;
      @(negedge clk);
      arm        = a;
      match      = m;
      tick       = t;
      snooze_btn = s;
      off_btn    = o;
      expQ.push_back({expState[3], expState[2], expState});
      tagQ.push_back(tag);
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         checkOutput("scoreboard_empty", 7'd0, 7'd1);
      end else begin
         expVal = expQ.pop_front();
         expTag = tagQ.pop_front();
         checkOutput(expTag, {snooze_led, buzzer, state}, expVal);
      end
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      rst_n      = 1'b0;
      arm        = 1'b0;
      match      = 1'b0;
      tick       = 1'b0;
      snooze_btn = 1'b0;
      off_btn    = 1'b0;

      // Reset state, checked while reset is held across a few edges.
      #22;
      checkOutput("reset_state", {snooze_led, buzzer, state}, {2'b00, S_OFF});
      @(negedge clk);
      rst_n = 1'b1;

      // Arm, then match to start ringing.
      applyStimulus(0, 0, 0, 0, 0, S_OFF,   "off_idle");
      applyStimulus(1, 0, 0, 0, 0, S_ARMED, "arm");
      applyStimulus(1, 0, 0, 0, 0, S_ARMED, "armed_wait");
      applyStimulus(1, 1, 0, 0, 0, S_RING,  "match_ring");

      // With no buttons pressed, the alarm stops on the edge after the fourth tick.
      applyStimulus(1, 1, 1, 0, 0, S_RING,  "ring_tick1");
      applyStimulus(1, 1, 0, 0, 0, S_RING,  "ring_gap");
      applyStimulus(1, 1, 1, 0, 0, S_RING,  "ring_tick2");
      applyStimulus(1, 1, 1, 0, 0, S_RING,  "ring_tick3");
      applyStimulus(1, 1, 1, 0, 0, S_DONE,  "ring_timeout");
      applyStimulus(1, 1, 0, 0, 0, S_DONE,  "done_hold_match");
      applyStimulus(1, 0, 0, 0, 0, S_ARMED, "done_rearm");

      // A snooze press enters SNOOZE. The third tick after that returns to RING.
      applyStimulus(1, 1, 0, 0, 0, S_RING,   "ring2");
      applyStimulus(1, 1, 0, 1, 0, S_SNOOZE, "snooze1");
      applyStimulus(1, 1, 0, 0, 0, S_SNOOZE, "snooze1_idle");
      applyStimulus(1, 1, 1, 0, 0, S_SNOOZE, "snooze1_tick1");
      applyStimulus(1, 1, 1, 0, 0, S_SNOOZE, "snooze1_tick2");
      applyStimulus(1, 1, 1, 0, 0, S_RING,   "snooze1_expire");

      // Second snooze. The button is held for 10 cycles and counts as one press.
      applyStimulus(1, 1, 0, 1, 0, S_SNOOZE, "hold_c1");
      applyStimulus(1, 1, 0, 1, 0, S_SNOOZE, "hold_c2");
      applyStimulus(1, 1, 1, 1, 0, S_SNOOZE, "hold_c3");
      applyStimulus(1, 1, 0, 1, 0, S_SNOOZE, "hold_c4");
      applyStimulus(1, 1, 1, 1, 0, S_SNOOZE, "hold_c5");
      applyStimulus(1, 1, 1, 1, 0, S_RING,   "hold_c6_expire");
      for (int i = 7; i <= 10; i++) begin
         applyStimulus(1, 1, 0, 1, 0, S_RING, $sformatf("hold_c%0d", i));
      end

      // Third snooze press: it is blocked by the tally limit only when
      // SNOOZE_LIMIT_EN is defined.
      applyStimulus(1, 1, 0, 0, 0, S_RING,         "release");
      applyStimulus(1, 1, 0, 1, 0, S_THIRD_SNOOZE, "third_snooze");
      applyStimulus(1, 1, 0, 0, 0, S_THIRD_SNOOZE, "third_snooze_hold");
      applyStimulus(1, 1, 0, 0, 1, S_DONE,         "off_press");

      // Off and snooze pressed together resolve to DONE.
      applyStimulus(1, 0, 0, 0, 0, S_ARMED, "rearm2");
      applyStimulus(1, 1, 0, 0, 0, S_RING,  "ring3");
      applyStimulus(1, 1, 0, 1, 1, S_DONE,  "off_and_snooze");

      // Dropping arm takes priority over an off press in the same cycle.
      applyStimulus(1, 0, 0, 0, 0, S_ARMED,  "rearm3");
      applyStimulus(1, 1, 0, 0, 0, S_RING,   "ring4");
      applyStimulus(1, 1, 0, 1, 0, S_SNOOZE, "snooze4");
      applyStimulus(0, 1, 0, 0, 1, S_OFF,    "disarm_beats_off");

      // Off press during SNOOZE.
      applyStimulus(1, 0, 0, 0, 0, S_ARMED,  "arm5");
      applyStimulus(1, 1, 0, 0, 0, S_RING,   "ring5");
      applyStimulus(1, 1, 0, 1, 0, S_SNOOZE, "snooze5");
      applyStimulus(1, 1, 0, 0, 1, S_DONE,   "snooze_off");

      // Asynchronous reset in the middle of SNOOZE.
      applyStimulus(1, 0, 0, 0, 0, S_ARMED,  "arm6");
      applyStimulus(1, 1, 0, 0, 0, S_RING,   "ring6");
      applyStimulus(1, 1, 0, 1, 0, S_SNOOZE, "snooze6");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", {snooze_led, buzzer, state}, {2'b00, S_OFF});
      @(posedge clk);
      #1;
      checkOutput("reset_held", {snooze_led, buzzer, state}, {2'b00, S_OFF});
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, S_OFF,   "post_reset_off");
      applyStimulus(1, 0, 0, 0, 0, S_ARMED, "post_reset_arm");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter SNOOZE_SEC, default 9, snooze duration in tick pulses (1..255).
REQ-002 Parameter RING_TIMEOUT_SEC, default 60, ring duration in tick pulses before auto-stop (1..255).
REQ-003 Parameter MAX_SNOOZE, default 3, snooze limit; used only under SNOOZE_LIMIT_EN.
REQ-004 clk  input  1  system clock; all flops rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 arm  input  1  alarm-enable switch, level, synchronous to clk.
REQ-007 match  input  1  current time equals alarm time, level, synchronous.
REQ-008 tick  input  1  one-cycle 1 Hz strobe, synchronous.
REQ-009 snooze_btn  input  1  snooze button level, synchronous, debounced upstream.
REQ-010 off_btn  input  1  off button level, synchronous, debounced upstream.
REQ-011 state  output  5  one-hot current state.
REQ-012 buzzer  output  1  alarm sound enable.
REQ-013 snooze_led  output  1  snooze indicator.

Function
REQ-014 State encoding SHALL be one-hot: OFF=5'b00001, ARMED=5'b00010, RING=5'b00100, SNOOZE=5'b01000, DONE=5'b10000.
REQ-015 State SHALL be held in a 5-bit register updated every clk edge from internally formed next-state logic.
REQ-016 Button presses SHALL be rising-edge detected internally (press = level high now, low previous cycle); a held button counts once.
REQ-017 Transition priority within every non-OFF state SHALL be: arm=0 -> OFF, then off press, then snooze press, then timer/match events.
REQ-018 OFF: arm=1 -> ARMED; else stay.
REQ-019 ARMED: match=1 -> RING; else stay.
REQ-020 RING: off press -> DONE; snooze press -> SNOOZE; tick while ring count = RING_TIMEOUT_SEC-1 -> DONE; else stay.
REQ-021 SNOOZE: off press -> DONE; tick while snooze count = 1 -> RING; else stay.
REQ-022 DONE: match=0 -> ARMED; else stay (prevents re-ring within the same matching minute).
REQ-023 Ring counter (8 bits) SHALL load 0 on every entry to RING and increment on each tick while in RING.
REQ-024 Snooze counter (8 bits) SHALL load SNOOZE_SEC on entry to SNOOZE and decrement on each tick while in SNOOZE; it never wraps below 0.
REQ-025 Any non-one-hot state value SHALL transition to OFF on the next clk edge.
REQ-026 buzzer SHALL equal state[2]; snooze_led SHALL equal state[3]; both driven directly from state flops, no added latency.
REQ-027 State change SHALL be visible on state exactly one clk after the qualifying input cycle.
REQ-028 Simultaneous off and snooze presses SHALL resolve to DONE.

Reset
REQ-029 rst_n low SHALL immediately force state to 5'b00001 (bit 0 preset, bits 4:1 cleared), independent of clk.
REQ-030 rst_n low SHALL clear ring counter, snooze counter, snooze tally and button-history flops to 0; buzzer and snooze_led read 0.
REQ-031 Reset asserted mid-RING or mid-SNOOZE SHALL abandon the cycle; after release the block starts in OFF.

Configuration
REQ-032 Macro SNOOZE_LIMIT_EN: when defined, a snooze tally increments on each RING->SNOOZE transition; snooze presses in RING SHALL be ignored once tally = MAX_SNOOZE; tally clears on entry to OFF or DONE.
REQ-033 Without SNOOZE_LIMIT_EN, snooze is unlimited and no tally logic exists.

Verification (SNOOZE_SEC=3, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2)
REQ-034 Reset then arm=1 -> state 00001 then 00010 next edge; match=1 -> 00100 next edge, buzzer=1.
REQ-035 RING, no buttons, 4 ticks -> state 10000 on edge after 4th tick; drop match -> 00010.
REQ-036 RING, snooze press -> 01000, snooze_led=1; 3 ticks -> 00100 on edge after 3rd tick.
REQ-037 SNOOZE, arm=0 and off press same cycle -> 00001 (arm priority); held snooze_btn for 10 cycles yields one transition only.
REQ-038 With SNOOZE_LIMIT_EN: two snooze cycles, third snooze press in RING -> stays 00100; without macro -> 01000.
REQ-039 Reset pulse mid-SNOOZE, asynchronous to clk -> state 00001 immediately, buzzer=0, snooze_led=0.
